// File: rtl/cel_row_unpacker_if.sv
// Handshake bundle between the DMA word fetcher, the CEL row unpacker and the pixel stage.
interface cel_row_unpacker_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic [15:0]       pix_data;
  logic [1:0]        pix_kind;
  logic              pix_valid;
  logic              pix_ready;

  modport master (
    output word_data, word_valid, pix_ready,
    input  word_ready, pix_data, pix_kind, pix_valid
  );

  modport slave (
    input  word_data, word_valid, pix_ready,
    output word_ready, pix_data, pix_kind, pix_valid
  );
endinterface

// File: rtl/cel_row_unpacker.sv
// CEL source-row unpacker: parses one packed or unpacked row per start and emits typed pixels,
// enforcing the row word-offset rule so the next row always begins on the right word.
module cel_row_unpacker #(
  parameter int WORD_W   = 32,
  parameter int BUF_W    = 64,
  parameter int CNT_W    = 6,
  parameter int ROWPIX_W = 11
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [2:0]          bpp_i,
  input  logic                packed_i,
  input  logic [ROWPIX_W-1:0] row_pixels_i,
  input  logic                start_i,
  cel_row_unpacker_if.slave   bus,
  output logic [9:0]          row_offset_o,
  output logic                row_done_o,
  output logic                busy_o,
  output logic                err_o
);
  localparam int LVL_W = $clog2(BUF_W + 1);
  localparam int RC_W  = ((CNT_W > ROWPIX_W) ? CNT_W : ROWPIX_W) + 1;
  localparam int WC_W  = ROWPIX_W + 5;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HDR  = 3'd1;
  localparam logic [2:0] PKT  = 3'd2;
  localparam logic [2:0] PIXF = 3'd3;
  localparam logic [2:0] POUT = 3'd4;
  localparam logic [2:0] SKIP = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [2:0]       bpp_q, bpp_d;
  logic             packed_q, packed_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [WC_W-1:0]  limit_q, limit_d;
  logic [RC_W-1:0]  rem_q, rem_d;
  logic [1:0]       kind_q, kind_d;
  logic [15:0]      pix_q, pix_d;
  logic [9:0]       off_q, off_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [4:0]       fieldW;
  logic             canTake, accept, wordReady;
  logic [15:0]      fieldVal;
  logic [LVL_W-1:0] consumeN, remain;
  logic [BUF_W-1:0] placed;
  logic [WC_W-1:0]  needBits, needWords;

  function automatic logic [4:0] bppBits(input logic [2:0] code);
    case (code)
      3'd1:    return 5'd1;
      3'd2:    return 5'd2;
      3'd3:    return 5'd4;
      3'd4:    return 5'd6;
      3'd5:    return 5'd8;
      3'd6:    return 5'd16;
      default: return 5'd0;
    endcase
  endfunction

  always_comb begin
    fieldW = 5'd0;
    case (state_q)
      HDR:     fieldW = (bpp_q >= 3'd5) ? 5'd16 : 5'd8;
      PKT:     fieldW = 5'd8;
      PIXF:    fieldW = bppBits(bpp_q);
      default: fieldW = 5'd0;
    endcase
  end

  // Valid bits sit left-aligned in buf_q; everything below lvl_q is kept zero so a new word can be ORed in.
  assign canTake   = (fieldW != 5'd0) && (lvl_q >= LVL_W'(fieldW));
  assign fieldVal  = buf_q[BUF_W-1 -: 16] >> (5'd16 - fieldW);
  assign consumeN  = canTake ? LVL_W'(fieldW) : '0;
  assign remain    = lvl_q - consumeN;
  assign placed    = {bus.word_data, {(BUF_W-WORD_W){1'b0}}} >> remain;
  assign wordReady = busy_o && (lvl_q <= LVL_W'(BUF_W - WORD_W)) && (wcnt_q < limit_q);
  assign accept    = bus.word_valid && wordReady;

  // Unpacked rows never fetch past their last data word, so the next row's first word is not swallowed.
  assign needBits  = (WC_W'(row_pixels_i) + WC_W'(1)) * WC_W'(bppBits(bpp_i));
  assign needWords = (needBits + WC_W'(WORD_W - 1)) / WC_W'(WORD_W);

  always_comb begin
    state_d  = state_q;
    bpp_d    = bpp_q;
    packed_d = packed_q;
    limit_d  = limit_q;
    rem_d    = rem_q;
    kind_d   = kind_q;
    pix_d    = pix_q;
    off_d    = off_q;
    err_d    = err_q;
    done_d   = 1'b0;
    wcnt_d   = accept ? wcnt_q + WC_W'(1) : wcnt_q;
    buf_d    = (buf_q << consumeN) | (accept ? placed : '0);
    lvl_d    = accept ? remain + LVL_W'(WORD_W) : remain;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (bppBits(bpp_i) == 5'd0) begin
            err_d = 1'b1;
          end else begin
            err_d    = 1'b0;
            bpp_d    = bpp_i;
            packed_d = packed_i;
            buf_d    = '0;
            lvl_d    = '0;
            wcnt_d   = '0;
            if (packed_i) begin
              limit_d = WC_W'(1);
              state_d = HDR;
            end else begin
              limit_d = needWords;
              rem_d   = RC_W'(row_pixels_i) + RC_W'(1);
              kind_d  = 2'b01;
              state_d = PIXF;
            end
          end
        end
      end
      HDR: begin
        if (canTake) begin
          off_d   = fieldVal[9:0];
          limit_d = WC_W'(fieldVal[9:0]) + WC_W'(2);
          state_d = PKT;
        end
      end
      PKT: begin
        if (canTake) begin
          rem_d  = RC_W'(fieldVal[CNT_W-1:0]) + RC_W'(1);
          kind_d = fieldVal[7:6];
          case (fieldVal[7:6])
            2'b00:   state_d = SKIP;
            2'b10: begin
              pix_d   = 16'd0;
              state_d = POUT;
            end
            default: state_d = PIXF;
          endcase
        end
      end
      PIXF: begin
        if (canTake) begin
          pix_d   = fieldVal;
          state_d = POUT;
        end
      end
      POUT: begin
        if (bus.pix_ready) begin
          rem_d = rem_q - RC_W'(1);
          if (rem_q == RC_W'(1)) begin
            state_d = packed_q ? PKT : SKIP;
          end else if (kind_q == 2'b01) begin
            state_d = PIXF;
          end
        end
      end
      SKIP: begin
        buf_d = '0;
        lvl_d = '0;
        if (wcnt_q == limit_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      bpp_q    <= '0;
      packed_q <= 1'b0;
      buf_q    <= '0;
      lvl_q    <= '0;
      wcnt_q   <= '0;
      limit_q  <= '0;
      rem_q    <= '0;
      kind_q   <= '0;
      pix_q    <= '0;
      off_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bpp_q    <= bpp_d;
      packed_q <= packed_d;
      buf_q    <= buf_d;
      lvl_q    <= lvl_d;
      wcnt_q   <= wcnt_d;
      limit_q  <= limit_d;
      rem_q    <= rem_d;
      kind_q   <= kind_d;
      pix_q    <= pix_d;
      off_q    <= off_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy_o         = (state_q != IDLE);
  assign row_done_o     = done_q;
  assign err_o          = err_q;
  assign row_offset_o   = off_q;
  assign bus.word_ready = wordReady;
  assign bus.pix_valid  = (state_q == POUT);
  assign bus.pix_data   = pix_q;
  assign bus.pix_kind   = kind_q;
endmodule
